// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: scans a 4x3 active-low matrix keypad one column at a
// time, synchronises and debounces the rows, and emits one 4-bit key code for
// a single clock per press. Idle code is 4'b1111.
//
// Handshake: key_valid qualifies key_code for exactly one cycle. There is no
// ready; the consumer must take the code in the cycle key_valid is high.
// key_busy covers the whole press, from first detection until the release
// has been debounced.
module keypad_scan_encoder #(
   parameter int SCAN_CYCLES     = 1_000,
   parameter int DEBOUNCE_CYCLES = 10_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [2:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_busy
);

   localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
   localparam logic [DEB_W-1:0]  DEB_DONE  = DEB_W'(DEBOUNCE_CYCLES);
   localparam logic [DEB_W-1:0]  REL_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ST_SCAN     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_EMIT     = 2'd2;
   localparam logic [1:0] ST_RELEASE  = 2'd3;

   localparam logic [3:0] CODE_IDLE = 4'b1111;

   logic [1:0]        state;
   logic [3:0]        rs_meta;
   logic [3:0]        rs;
   logic [3:0]        cand_rows;
   logic [SCAN_W-1:0] scan_cnt;
   logic [DEB_W-1:0]  deb_cnt;
   logic              single_low;
   logic [1:0]        row_idx;
   logic [1:0]        col_idx;
   logic [3:0]        enc_code;

   // Two-flop synchroniser; rows idle high so reset loads all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_meta <= 4'b1111;
         rs      <= 4'b1111;
      end else begin
         rs_meta <= row_in;
         rs      <= rs_meta;
      end
   end

   // Exactly one synchronised row low is the only pattern that starts a press.
   always_comb begin
      single_low = 1'b0;
      case (rs)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
         default:                            single_low = 1'b0;
      endcase
   end

   // Decode the latched row pattern and the frozen column into the key code.
   always_comb begin
      row_idx  = 2'd0;
      col_idx  = 2'd0;
      enc_code = CODE_IDLE;
      case (cand_rows)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
      case (col_out)
         3'b110:  col_idx = 2'd0;
         3'b101:  col_idx = 2'd1;
         3'b011:  col_idx = 2'd2;
         default: col_idx = 2'd0;
      endcase
      case ({row_idx, col_idx})
         4'b00_00: enc_code = 4'b0001;
         4'b00_01: enc_code = 4'b0010;
         4'b00_10: enc_code = 4'b0011;
         4'b01_00: enc_code = 4'b0100;
         4'b01_01: enc_code = 4'b0101;
         4'b01_10: enc_code = 4'b0110;
         4'b10_00: enc_code = 4'b0111;
         4'b10_01: enc_code = 4'b1000;
         4'b10_10: enc_code = 4'b1001;
         4'b11_00: enc_code = 4'b1101;
         4'b11_01: enc_code = 4'b0000;
         4'b11_10: enc_code = 4'b1110;
         default:  enc_code = CODE_IDLE;
      endcase
   end

   // Scan / debounce / emit / release sequencer with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_SCAN;
         col_out   <= 3'b110;
         cand_rows <= 4'b1111;
         scan_cnt  <= '0;
         deb_cnt   <= '0;
         key_code  <= CODE_IDLE;
         key_valid <= 1'b0;
      end else begin
         key_code  <= CODE_IDLE;
         key_valid <= 1'b0;
         case (state)
            ST_SCAN: begin
               if (single_low) begin
                  // Column stays frozen from here until the release completes.
                  cand_rows <= rs;
                  deb_cnt   <= DEB_W'(1);
                  state     <= ST_DEBOUNCE;
               end else if (scan_cnt == SCAN_LAST) begin
                  scan_cnt <= '0;
                  col_out  <= {col_out[1:0], col_out[2]};
               end else begin
                  scan_cnt <= scan_cnt + SCAN_W'(1);
               end
            end
            ST_DEBOUNCE: begin
               if (rs == cand_rows) begin
                  if (deb_cnt == DEB_DONE) begin
                     key_code  <= enc_code;
                     key_valid <= 1'b1;
                     state     <= ST_EMIT;
                  end else begin
                     deb_cnt <= deb_cnt + DEB_W'(1);
                  end
               end else begin
                  // Bounce, release or a second row: abandon quietly.
                  scan_cnt <= '0;
                  state    <= ST_SCAN;
               end
            end
            ST_EMIT: begin
               deb_cnt <= '0;
               state   <= ST_RELEASE;
            end
            ST_RELEASE: begin
               if (rs == 4'b1111) begin
                  if (deb_cnt == REL_LAST) begin
                     scan_cnt <= '0;
                     state    <= ST_SCAN;
                  end else begin
                     deb_cnt <= deb_cnt + DEB_W'(1);
                  end
               end else begin
                  deb_cnt <= '0;
               end
            end
            default: state <= ST_SCAN;
         endcase
      end
   end

   // Busy for every state that belongs to a press in progress.
   assign key_busy = (state != ST_SCAN);

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with SCAN_CYCLES=2, DEBOUNCE_CYCLES=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_keypad_scan_encoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] row_in = 4'b1111;
   logic [2:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_busy;

   int vectors = 0;
   int miscompares = 0;

   keypad_scan_encoder #(
      .SCAN_CYCLES    (2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .row_in   (row_in),
      .col_out  (col_out),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_busy (key_busy)
   );

   // Clock generation
   always #5 clk = ~clk;

   // Hard time limit so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Return 1 unit after the edge on which col_out switched to target.
   task automatic wait_col_enter(input logic [2:0] target, input string tag);
      logic [2:0] last;
      bit         found;
      last  = col_out;
      found = 1'b0;
      for (int i = 0; i < 24 && !found; i++) begin
         tick();
         if (col_out == target && last != target) found = 1'b1;
         last = col_out;
      end
      check(tag, {3'b000, found}, 4'b0001);
   endtask

   // Drop a row just after the previous column went active, so the key is
   // detected while key_col is driven; check latency, code and no repeat.
   task automatic press_emit(input logic [3:0] rows, input logic [2:0] prev_col,
                             input logic [2:0] key_col, input logic [3:0] exp_code,
                             input string tag);
      wait_col_enter(prev_col, {tag, "_col"});
      row_in = rows;
      for (int i = 0; i < 6; i++) begin
         tick();
         check({tag, "_pre_valid"}, {3'b000, key_valid}, 4'b0000);
      end
      tick();
      check({tag, "_valid"}, {3'b000, key_valid}, 4'b0001);
      check({tag, "_code"}, key_code, exp_code);
      check({tag, "_busy"}, {3'b000, key_busy}, 4'b0001);
      check({tag, "_frozen_col"}, {1'b0, col_out}, {1'b0, key_col});
      tick();
      check({tag, "_one_shot"}, {3'b000, key_valid}, 4'b0000);
      check({tag, "_idle_code"}, key_code, 4'b1111);
      tick();
      tick();
      check({tag, "_held_no_repeat"}, {3'b000, key_valid}, 4'b0000);
      check({tag, "_held_busy"}, {3'b000, key_busy}, 4'b0001);
   endtask

   // Release cleanly: busy holds for DEBOUNCE_CYCLES clean samples plus sync delay.
   task automatic release_clean(input string tag);
      row_in = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         check({tag, "_rel_busy"}, {3'b000, key_busy}, 4'b0001);
         check({tag, "_rel_valid"}, {3'b000, key_valid}, 4'b0000);
      end
      tick();
      check({tag, "_rel_done"}, {3'b000, key_busy}, 4'b0000);
   endtask

   initial begin
      logic [3:0] seen;

      // 1. Reset held while rows toggle.
      row_in = 4'b1010;
      tick();
      row_in = 4'b0101;
      tick();
      check("rst_col", {1'b0, col_out}, 4'b0110);
      check("rst_code", key_code, 4'b1111);
      check("rst_valid", {3'b000, key_valid}, 4'b0000);
      check("rst_busy", {3'b000, key_busy}, 4'b0000);
      row_in = 4'b1111;
      tick();
      tick();
      rst_n = 1'b1;

      // 2. Key '5': row1, col1.
      press_emit(4'b1101, 3'b110, 3'b101, 4'b0101, "key5");
      release_clean("key5");

      // 3. Row3 across all columns: '*', '0', '#'.
      press_emit(4'b0111, 3'b011, 3'b110, 4'b1101, "star");
      release_clean("star");
      press_emit(4'b0111, 3'b110, 3'b101, 4'b0000, "zero");
      release_clean("zero");
      press_emit(4'b0111, 3'b101, 3'b011, 4'b1110, "hash");
      release_clean("hash");

      // 4. Bounce on row0: low 2, high 1, low 2, then release.
      row_in = 4'b1110;
      tick();
      check("bounce_a", {3'b000, key_valid}, 4'b0000);
      tick();
      check("bounce_a", {3'b000, key_valid}, 4'b0000);
      row_in = 4'b1111;
      tick();
      check("bounce_gap", {3'b000, key_valid}, 4'b0000);
      row_in = 4'b1110;
      tick();
      check("bounce_b", {3'b000, key_valid}, 4'b0000);
      tick();
      check("bounce_b", {3'b000, key_valid}, 4'b0000);
      row_in = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("bounce_after", {3'b000, key_valid}, 4'b0000);
      end
      seen = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         tick();
         case (col_out)
            3'b110:  seen[0] = 1'b1;
            3'b101:  seen[1] = 1'b1;
            3'b011:  seen[2] = 1'b1;
            default: seen[3] = 1'b1;
         endcase
      end
      check("bounce_rotate", seen, 4'b0111);

      // 5a. Two rows low at once (row0 + row2).
      row_in = 4'b1010;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("two_rows_valid", {3'b000, key_valid}, 4'b0000);
         check("two_rows_busy", {3'b000, key_busy}, 4'b0000);
      end
      row_in = 4'b1111;
      tick();
      tick();
      tick();

      // 5b. Key '1' with a one-cycle glitch during release.
      press_emit(4'b1110, 3'b011, 3'b110, 4'b0001, "key1");
      row_in = 4'b1111;
      tick();
      tick();
      row_in = 4'b1110;
      tick();
      row_in = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("glitch_busy", {3'b000, key_busy}, 4'b0001);
         check("glitch_valid", {3'b000, key_valid}, 4'b0000);
      end
      tick();
      check("glitch_done", {3'b000, key_busy}, 4'b0000);

      // 6. Reset asserted mid-debounce on key '5'.
      wait_col_enter(3'b110, "midrst_col");
      row_in = 4'b1101;
      for (int i = 0; i < 4; i++) tick();
      check("midrst_in_debounce", {3'b000, key_busy}, 4'b0001);
      rst_n = 1'b0;
      #1;
      check("midrst_col_out", {1'b0, col_out}, 4'b0110);
      check("midrst_code", key_code, 4'b1111);
      check("midrst_valid", {3'b000, key_valid}, 4'b0000);
      check("midrst_busy", {3'b000, key_busy}, 4'b0000);
      row_in = 4'b1111;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("midrst_restart_col", {1'b0, col_out}, 4'b0110);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("midrst_no_emit", {3'b000, key_valid}, 4'b0000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
